ysyx_220053_id_stage: RTL and testbench

Pipelined, parametrised instruction-decode stage for the ysyx_220053 core. It sits between fetch and execute:
- buffers fetched instructions in a DEPTH-entry queue;
- decodes register indices, immediate, write-enable and trap/CSR fields;
- blocks issue on register read-after-write hazards using a pending-writeback scoreboard;
- presents one decoded instruction per cycle to execute over a valid/ready handshake, with a single-cycle flush for redirects.

---
 rtl/ysyx_220053_id_stage_if.sv | 38 +++
 rtl/ysyx_220053_id_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_ysyx_220053_id_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_id_stage_if.sv
// Fetch / execute / writeback bundle around the ysyx_220053 decode stage.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface ysyx_220053_id_stage_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  logic                       if_valid;
  logic                       if_ready;
  logic [XLEN-1:0]            if_pc;
  logic [31:0]                if_instr;
  logic                       id_valid;
  logic                       id_ready;
  logic [XLEN-1:0]            id_pc;
  logic [31:0]                id_instr;
  logic [4:0]                 id_rd;
  logic [4:0]                 id_rs1;
  logic [4:0]                 id_rs2;
  logic [XLEN-1:0]            id_imm;
  logic                       id_wen;
  logic                       id_ecall;
  logic [11:0]                id_csr_id;
  logic                       wb_valid;
  logic [4:0]                 wb_rd;
  logic                       flush;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  modport slave (
    input  if_valid, if_pc, if_instr, id_ready, wb_valid, wb_rd, flush,
    output if_ready, id_valid, id_pc, id_instr, id_rd, id_rs1, id_rs2,
           id_imm, id_wen, id_ecall, id_csr_id, occupancy
  );

  modport master (
    output if_valid, if_pc, if_instr, id_ready, wb_valid, wb_rd, flush,
    input  if_ready, id_valid, id_pc, id_instr, id_rd, id_rs1, id_rs2,
           id_imm, id_wen, id_ecall, id_csr_id, occupancy
  );
endinterface

// File: rtl/ysyx_220053_id_stage.sv
// ysyx_220053 decode stage: fetch queue, field decode, RAW scoreboard and issue register.

// Generic circular FIFO with a peekable head; rst or flush empties it in one cycle.
// Latency: an entry pushed at edge N is visible on head_dat after edge N.
// Backpressure: caller must not push when full nor pop when empty.
module ysyx_220053_id_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
endmodule

// Decode stage: queues fetched instructions, decodes the head, issues it when free of RAW hazards.
// Latency: enqueue at edge N, earliest issue at edge N+1; one instruction per cycle sustained.
// Backpressure: if_ready low when the queue is full, during flush or reset; outputs hold while id_ready is low.
module ysyx_220053_id_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_220053_id_stage_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            wen;
    logic            ecall;
    logic            use_rs1;
    logic            use_rs2;
    logic [11:0]     csr_id;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] op;
    op       = ins[6:0];
    d        = '0;
    d.ecall  = (ins == 32'h0000_0073);
    d.rd     = ins[11:7];
    d.rs1    = d.ecall ? 5'd17 : ins[19:15];
    d.rs2    = ins[24:20];
    d.csr_id = d.ecall ? 12'h342 : ins[31:20];
    d.wen    = (ins[11:7] != 5'd0) && (op != OP_BRANCH) && (op != OP_STORE) &&
               !((op == OP_SYSTEM) && (ins[14:12] == 3'd0));
    case (op)
      OP_LUI, OP_AUIPC: begin
        d.imm = XLEN'($signed({ins[31:12], 12'b0}));
      end
      OP_JAL: begin
        d.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM32, OP_SYSTEM: begin
        d.imm     = XLEN'($signed(ins[31:20]));
        d.use_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        d.imm     = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
      end
      OP_STORE: begin
        d.imm     = XLEN'($signed({ins[31:25], ins[11:7]}));
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
      end
      OP_REG, OP_REG32: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
      end
      default: d.imm = '0;
    endcase
    return d;
  endfunction

  entry_t          in_ent;
  entry_t          head;
  dec_t            hd;
  logic            if_ready;
  logic            enq;
  logic            issue;
  logic            hazard;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   count;
  logic [31:0]     pend;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  logic            id_valid_q;
  logic [XLEN-1:0] id_pc_q;
  logic [31:0]     id_instr_q;
  logic [4:0]      id_rd_q;
  logic [4:0]      id_rs1_q;
  logic [4:0]      id_rs2_q;
  logic [XLEN-1:0] id_imm_q;
  logic            id_wen_q;
  logic            id_ecall_q;
  logic [11:0]     id_csr_q;

  assign in_ent.pc    = bus.if_pc;
  assign in_ent.instr = bus.if_instr;
  assign if_ready     = !fifo_full && !bus.flush && !rst;
  assign enq          = bus.if_valid && if_ready;

  ysyx_220053_id_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .push     (enq),
    .push_dat (in_ent),
    .pop      (issue),
    .head_dat (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A retiring writeback releases its register in the same cycle it is checked.
  always_comb begin
    hd       = decode(head.instr);
    clr_mask = bus.wb_valid ? (32'd1 << bus.wb_rd) : 32'd0;
    hazard   = (hd.use_rs1 && (hd.rs1 != 5'd0) && pend[hd.rs1] && !clr_mask[hd.rs1]) ||
               (hd.use_rs2 && (hd.rs2 != 5'd0) && pend[hd.rs2] && !clr_mask[hd.rs2]);
    issue    = !fifo_empty && (!id_valid_q || bus.id_ready) && !hazard && !bus.flush;
    set_mask = (issue && hd.wen) ? (32'd1 << hd.rd) : 32'd0;
  end

  // Flush leaves pending bits alone: older writes already in flight still retire.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= ((pend & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_rd_q    <= '0;
      id_rs1_q   <= '0;
      id_rs2_q   <= '0;
      id_imm_q   <= '0;
      id_wen_q   <= 1'b0;
      id_ecall_q <= 1'b0;
      id_csr_q   <= '0;
    end else if (bus.flush) begin
      id_valid_q <= 1'b0;
    end else if (issue) begin
      id_valid_q <= 1'b1;
      id_pc_q    <= head.pc;
      id_instr_q <= head.instr;
      id_rd_q    <= hd.rd;
      id_rs1_q   <= hd.rs1;
      id_rs2_q   <= hd.rs2;
      id_imm_q   <= hd.imm;
      id_wen_q   <= hd.wen;
      id_ecall_q <= hd.ecall;
      id_csr_q   <= hd.csr_id;
    end else if (bus.id_ready) begin
      id_valid_q <= 1'b0;
    end
  end

  assign bus.if_ready  = if_ready;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_rd     = id_rd_q;
  assign bus.id_rs1    = id_rs1_q;
  assign bus.id_rs2    = id_rs2_q;
  assign bus.id_imm    = id_imm_q;
  assign bus.id_wen    = id_wen_q;
  assign bus.id_ecall  = id_ecall_q;
  assign bus.id_csr_id = id_csr_q;
  assign bus.occupancy = count;
endmodule

// File: tb/tb_ysyx_220053_id_stage.sv
// Bench for ysyx_220053_id_stage: decode vector table, hazard/fill/flush sequences, random run against a queue model.
module tb_ysyx_220053_id_stage;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_220053_id_stage_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  ysyx_220053_id_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    bit          wen, ecall;
    logic [11:0] csr;
  } vec_t;

  typedef struct {
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    bit          wen, ecall, use1, use2;
    logic [11:0] csr;
  } rdec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  vec_t       vt[12];
  ent_t       mq[$];
  ent_t       mout;
  bit         mv;
  bit         mpend[32];
  logic [6:0] ops[12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                          7'h1B, 7'h73, 7'h63, 7'h23, 7'h33, 7'h3B};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle;
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0; bus.id_ready = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.flush = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] instr);
    bus.if_valid = 1'b1; bus.if_pc = pc; bus.if_instr = instr;
  endtask

  // Reference decode written from the ISA immediate layouts using signed arithmetic shifts.
  function automatic rdec_t ref_dec(input logic [31:0] w);
    rdec_t              d;
    byte                fmt;
    logic signed [31:0] s32;
    logic signed [63:0] sw, hi;
    s32 = w;
    sw  = s32;
    case (w[6:0])
      7'h37, 7'h17:                      fmt = "U";
      7'h6F:                             fmt = "J";
      7'h67, 7'h03, 7'h13, 7'h1B, 7'h73: fmt = "I";
      7'h63:                             fmt = "B";
      7'h23:                             fmt = "S";
      7'h33, 7'h3B:                      fmt = "R";
      default:                           fmt = "X";
    endcase
    d.imm = 64'd0;
    case (fmt)
      "U": d.imm = sw & ~64'hFFF;
      "I": begin hi = sw >>> 20; d.imm = hi; end
      "S": begin hi = sw >>> 25; d.imm = (hi <<< 5) | 64'(w[11:7]); end
      "B": begin
        hi = sw >>> 31;
        d.imm = (hi <<< 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1);
      end
      "J": begin
        hi = sw >>> 31;
        d.imm = (hi <<< 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11) | (64'(w[30:21]) << 1);
      end
      default: d.imm = 64'd0;
    endcase
    d.ecall = (w == 32'h73);
    d.rd    = w[11:7];
    d.rs1   = d.ecall ? 5'd17 : w[19:15];
    d.rs2   = w[24:20];
    d.csr   = d.ecall ? 12'h342 : w[31:20];
    d.wen   = (d.rd != 0) && fmt != "B" && fmt != "S" && !(w[6:0] == 7'h73 && w[14:12] == 3'd0);
    d.use1  = (fmt == "I") || (fmt == "B") || (fmt == "S") || (fmt == "R");
    d.use2  = (fmt == "B") || (fmt == "S") || (fmt == "R");
    return d;
  endfunction

  function automatic bit ref_haz(input rdec_t d, input bit wbv, input logic [4:0] wbr);
    bit h = 1'b0;
    if (d.use1 && d.rs1 != 0 && mpend[d.rs1] && !(wbv && wbr == d.rs1)) h = 1'b1;
    if (d.use2 && d.rs2 != 0 && mpend[d.rs2] && !(wbv && wbr == d.rs2)) h = 1'b1;
    return h;
  endfunction

  function automatic logic [4:0] rreg();
    int k = $urandom_range(0, 8);
    return (k == 8) ? 5'd17 : k[4:0];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          pick;
    w    = $urandom;
    pick = $urandom_range(0, 12);
    if (pick == 12) return 32'h0000_0073;
    w[6:0]   = ops[pick];
    w[11:7]  = rreg();
    w[19:15] = rreg();
    w[24:20] = rreg();
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    vt[0]  = '{32'h00500093, 5'd1,  5'd0,  5'd5,  64'd5,                   1, 0, 12'h005};
    vt[1]  = '{32'h00000073, 5'd0,  5'd17, 5'd0,  64'd0,                   0, 1, 12'h342};
    vt[2]  = '{32'hFE000EE3, 5'd29, 5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 12'hFE0};
    vt[3]  = '{32'h800002B7, 5'd5,  5'd0,  5'd0,  64'hFFFF_FFFF_8000_0000, 1, 0, 12'h800};
    vt[4]  = '{32'h00108133, 5'd2,  5'd1,  5'd1,  64'd0,                   1, 0, 12'h001};
    vt[5]  = '{32'hFE512C23, 5'd24, 5'd2,  5'd5,  64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 12'hFE5};
    vt[6]  = '{32'h008000EF, 5'd1,  5'd0,  5'd8,  64'd8,                   1, 0, 12'h008};
    vt[7]  = '{32'h300021F3, 5'd3,  5'd0,  5'd0,  64'h300,                 1, 0, 12'h300};
    vt[8]  = '{32'h000000F3, 5'd1,  5'd0,  5'd0,  64'd0,                   0, 0, 12'h000};
    vt[9]  = '{32'h12345517, 5'd10, 5'd8,  5'd3,  64'h1234_5000,           1, 0, 12'h123};
    vt[10] = '{32'h0040A003, 5'd0,  5'd1,  5'd4,  64'd4,                   0, 0, 12'h004};
    vt[11] = '{32'hFFF3839B, 5'd7,  5'd7,  5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 12'hFFF};

    // Reset state
    rst = 1'b1;
    idle();
    tick();
    tick();
    #1;
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_valid", bus.id_valid, 0);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_pc", bus.id_pc, 0);
    chk("rst_imm", bus.id_imm, 0);
    chk("rst_csr", bus.id_csr_id, 0);
    chk("rst_wen", bus.id_wen, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_if_ready", bus.if_ready, 1);

    // Decode table: one instruction per fresh reset, checked on the issue cycle
    for (int i = 0; i < 12; i++) begin
      do_reset();
      bus.id_ready = 1'b1;
      push(64'h8000_0000 + 64'(4 * i), vt[i].instr);
      tick();
      bus.if_valid = 1'b0;
      chk($sformatf("v%0d_occ_enq", i), bus.occupancy, 1);
      chk($sformatf("v%0d_valid_early", i), bus.id_valid, 0);
      tick();
      chk($sformatf("v%0d_valid", i), bus.id_valid, 1);
      chk($sformatf("v%0d_pc", i), bus.id_pc, 64'h8000_0000 + 64'(4 * i));
      chk($sformatf("v%0d_instr", i), bus.id_instr, vt[i].instr);
      chk($sformatf("v%0d_rd", i), bus.id_rd, vt[i].rd);
      chk($sformatf("v%0d_rs1", i), bus.id_rs1, vt[i].rs1);
      chk($sformatf("v%0d_rs2", i), bus.id_rs2, vt[i].rs2);
      chk($sformatf("v%0d_imm", i), bus.id_imm, vt[i].imm);
      chk($sformatf("v%0d_wen", i), bus.id_wen, vt[i].wen);
      chk($sformatf("v%0d_ecall", i), bus.id_ecall, vt[i].ecall);
      chk($sformatf("v%0d_csr", i), bus.id_csr_id, vt[i].csr);
      chk($sformatf("v%0d_occ_iss", i), bus.occupancy, 0);
      tick();
      chk($sformatf("v%0d_consumed", i), bus.id_valid, 0);
    end

    // RAW hazard held until writeback, which releases it at the same edge
    do_reset();
    bus.id_ready = 1'b1;
    push(64'h100, 32'h00500093);
    tick();
    push(64'h104, 32'h00108133);
    tick();
    bus.if_valid = 1'b0;
    chk("haz_first_rd", bus.id_rd, 1);
    repeat (4) tick();
    chk("haz_held_valid", bus.id_valid, 0);
    chk("haz_held_occ", bus.occupancy, 1);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    tick();
    bus.wb_valid = 1'b0;
    chk("haz_rel_valid", bus.id_valid, 1);
    chk("haz_rel_pc", bus.id_pc, 64'h104);
    chk("haz_rel_rs1", bus.id_rs1, 1);
    chk("haz_rel_rs2", bus.id_rs2, 1);
    chk("haz_rel_occ", bus.occupancy, 0);

    // Fill with execute stalled, then drain in order across the pointer wrap
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push(64'h200 + 64'(4 * k), (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13);
      tick();
    end
    push(64'h300, 32'h00000013);
    #1;
    chk("fill_occ", bus.occupancy, 4);
    chk("fill_if_ready", bus.if_ready, 0);
    chk("fill_out_pc", bus.id_pc, 64'h200);
    tick();
    bus.if_valid = 1'b0;
    chk("fill_no_overrun", bus.occupancy, 4);
    chk("fill_stall_hold", bus.id_pc, 64'h200);
    bus.id_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk($sformatf("drain%0d_valid", k), bus.id_valid, 1);
      chk($sformatf("drain%0d_pc", k), bus.id_pc, 64'h200 + 64'(4 * k));
      chk($sformatf("drain%0d_imm", k), bus.id_imm, 64'(k));
    end
    tick();
    chk("drain_empty_valid", bus.id_valid, 0);
    chk("drain_empty_occ", bus.occupancy, 0);
    for (int k = 0; k < 6; k++) begin
      push(64'h400 + 64'(4 * k), 32'h00000013);
      tick();
      if (k > 0) chk($sformatf("stream%0d_pc", k), bus.id_pc, 64'h400 + 64'(4 * (k - 1)));
    end
    bus.if_valid = 1'b0;
    tick();
    chk("stream_last_pc", bus.id_pc, 64'h414);
    chk("stream_occ", bus.occupancy, 0);

    // Flush drops queue and output register but keeps pending writes
    do_reset();
    push(64'h500, 32'h00500093);
    tick();
    for (int k = 1; k < 4; k++) begin
      push(64'h500 + 64'(4 * k), 32'h00000013);
      tick();
    end
    chk("pre_flush_occ", bus.occupancy, 3);
    chk("pre_flush_valid", bus.id_valid, 1);
    push(64'h5F0, 32'h00000013);
    bus.flush = 1'b1;
    #1;
    chk("flush_if_ready", bus.if_ready, 0);
    tick();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    chk("flush_occ", bus.occupancy, 0);
    chk("flush_valid", bus.id_valid, 0);
    bus.id_ready = 1'b1;
    push(64'h600, 32'h00108133);
    tick();
    bus.if_valid = 1'b0;
    repeat (3) tick();
    chk("flush_pend_kept_valid", bus.id_valid, 0);
    chk("flush_pend_kept_occ", bus.occupancy, 1);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    tick();
    bus.wb_valid = 1'b0;
    chk("flush_wb_issue_valid", bus.id_valid, 1);
    chk("flush_wb_issue_pc", bus.id_pc, 64'h600);

    // Random traffic against the queue/scoreboard model
    do_reset();
    mq.delete();
    mv = 1'b0;
    foreach (mpend[i]) mpend[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit    rdy, enq, iss, wbv;
      rdec_t hd, od;
      logic [4:0] wbr;
      bus.if_valid = ($urandom_range(0, 99) < 70);
      bus.if_pc    = {32'h0, $urandom};
      bus.if_instr = rand_instr();
      bus.id_ready = ($urandom_range(0, 99) < 75);
      wbv          = ($urandom_range(0, 99) < 35);
      wbr          = rreg();
      bus.wb_valid = wbv;
      bus.wb_rd    = wbr;
      bus.flush    = ($urandom_range(0, 99) < 2);
      #1;
      rdy = (mq.size() < DEPTH) && !bus.flush;
      chk("r_if_ready", bus.if_ready, rdy);
      chk("r_valid", bus.id_valid, mv);
      chk("r_occ", bus.occupancy, 64'(mq.size()));
      if (mv) begin
        od = ref_dec(mout.instr);
        chk("r_pc", bus.id_pc, mout.pc);
        chk("r_instr", bus.id_instr, mout.instr);
        chk("r_rd", bus.id_rd, od.rd);
        chk("r_rs1", bus.id_rs1, od.rs1);
        chk("r_rs2", bus.id_rs2, od.rs2);
        chk("r_imm", bus.id_imm, od.imm);
        chk("r_wen", bus.id_wen, od.wen);
        chk("r_ecall", bus.id_ecall, od.ecall);
        chk("r_csr", bus.id_csr_id, od.csr);
      end
      enq = bus.if_valid && rdy;
      iss = 1'b0;
      hd  = ref_dec(32'h0);
      if (bus.flush) begin
        mq.delete();
        mv = 1'b0;
      end else begin
        if (mq.size() > 0 && (!mv || bus.id_ready)) begin
          hd  = ref_dec(mq[0].instr);
          iss = !ref_haz(hd, wbv, wbr);
        end
        if (iss) begin
          mout = mq.pop_front();
          mv   = 1'b1;
        end else if (bus.id_ready) begin
          mv = 1'b0;
        end
        if (enq) mq.push_back('{bus.if_pc, bus.if_instr});
      end
      if (wbv) mpend[wbr] = 1'b0;
      if (iss && hd.wen) mpend[hd.rd] = 1'b1;
      mpend[0] = 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
